// File: rtl/comp2_recomposer.sv
// Serial sign-magnitude to two's complement converter, LSB first, one bit per clock.
// Applies the copy-through-first-1-then-invert rule to a DW-bit magnitude and produces a DW+1-bit result.
module comp2_recomposer #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic [DW-1:0] i_val,
    input  logic          i_sign,
    output logic [DW:0]   o_val,
    output logic          o_ready,
    output logic          o_done
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DW - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [DW-1:0] in_q;
    logic [DW-1:0] out_q;
    logic          sign_q;
    logic          seen_q;
    logic [CW-1:0] cnt_q;
    logic [DW:0]   val_q;
    logic          ready_q;
    logic          done_q;

    logic          out_bit;
    logic          seen_d;
    logic [DW-1:0] in_d;
    logic [DW-1:0] out_d;

    // Once a 1 has passed through on a negative operand, every later bit is inverted.
    always_comb begin
        out_bit = in_q[0] ^ (sign_q & seen_q);
        seen_d  = seen_q | in_q[0];
        in_d    = {1'b0, in_q[DW-1:1]};
        out_d   = {out_bit, out_q[DW-1:1]};
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            in_q    <= '0;
            out_q   <= '0;
            sign_q  <= 1'b0;
            seen_q  <= 1'b0;
            cnt_q   <= '0;
            val_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        in_q    <= i_val;
                        sign_q  <= i_sign;
                        seen_q  <= 1'b0;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    in_q   <= in_d;
                    out_q  <= out_d;
                    seen_q <= seen_d;
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_q == LAST_BIT) begin
                        ready_q <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // Bit DW is set only when a negative operand had a nonzero magnitude.
                    val_q  <= {sign_q & seen_q, out_q};
                    done_q <= 1'b1;
                    if (i_start) begin
                        in_q    <= i_val;
                        sign_q  <= i_sign;
                        seen_q  <= 1'b0;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        state_q <= CONV;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_val   = val_q;
    assign o_ready = ready_q;
    assign o_done  = done_q;

endmodule

// File: tb/tb_comp2_recomposer.sv
// Scoreboard bench for comp2_recomposer: the driver pushes expected results, a monitor pops them on o_done.
// Expected values come from plain negation arithmetic or literal constants.
module tb_comp2_recomposer;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start;
    logic [DW-1:0] i_val;
    logic          i_sign;
    logic [DW:0]   o_val;
    logic          o_ready;
    logic          o_done;

    int tests    = 0;
    int fails    = 0;
    int done_cnt = 0;
    int acc_cnt  = 0;
    logic [DW:0] sb_q[$];

    comp2_recomposer #(.DW(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_start (i_start),
        .i_val   (i_val),
        .i_sign  (i_sign),
        .o_val   (o_val),
        .o_ready (o_ready),
        .o_done  (o_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW:0] model(input logic [DW-1:0] mag, input logic sgn);
        logic [DW:0] ext;
        ext = {1'b0, mag};
        return sgn ? (~ext + 1'b1) : ext;
    endfunction

    // Monitor: every o_done pulse must match the oldest outstanding expectation.
    initial begin
        logic [DW:0] e;
        forever begin
            @(negedge clk);
            if (o_done === 1'b1) begin
                done_cnt++;
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_done: got o_done=1 o_val=%0h expected no pulse", o_val);
                end else begin
                    e = sb_q.pop_front();
                    check("o_val", 32'(o_val), 32'(e));
                end
            end
        end
    end

    task automatic wait_ready();
        int w = 0;
        while (o_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("ready_timeout", 32'(o_ready), 32'd1);
    endtask

    // Issue one operand at a negedge and return at the negedge where o_done is seen.
    task automatic run_one(input logic [DW-1:0] v, input logic s, input logic [DW:0] e,
                           output int lat, output int low);
        wait_ready();
        i_val = v; i_sign = s; i_start = 1'b1;
        sb_q.push_back(e);
        acc_cnt++;
        lat = -1;
        low = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            i_start = 1'b0;
            if (o_ready === 1'b0) low++;
            if (o_done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    typedef struct {
        logic [DW-1:0] v;
        logic          s;
        logic [DW:0]   e;
    } vec_t;

    initial begin
        int lat, low, snap, gap, w;
        vec_t dir[4];
        logic [DW-1:0] rv;
        logic          rs;

        rst = 1'b1; i_start = 1'b0; i_val = '0; i_sign = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_o_val", 32'(o_val), 32'h0);
        check("rst_o_ready", 32'(o_ready), 32'd1);
        check("rst_o_done", 32'(o_done), 32'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_hold", {o_val, o_ready, o_done}, {9'h000, 1'b1, 1'b0});
        end

        // Positive pass-through with latency and busy window measured.
        run_one(8'hC8, 1'b0, 9'h0C8, lat, low);
        check("latency", lat, 10);
        check("ready_low_cycles", low, 8);
        repeat (10) @(negedge clk);
        check("idle_keeps_o_val", 32'(o_val), 32'h0C8);

        dir[0] = '{8'h05, 1'b1, 9'h1FB};
        dir[1] = '{8'hFF, 1'b1, 9'h101};
        dir[2] = '{8'h01, 1'b1, 9'h1FF};
        dir[3] = '{8'h80, 1'b1, 9'h180};
        foreach (dir[i]) begin
            run_one(dir[i].v, dir[i].s, dir[i].e, lat, low);
            check("dir_latency", lat, 10);
        end

        // Negative zero, then a back-to-back start issued during the DONE cycle.
        @(negedge clk);
        wait_ready();
        i_val = 8'h00; i_sign = 1'b1; i_start = 1'b1;
        sb_q.push_back(9'h000); acc_cnt++;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            i_start = 1'b0;
        end
        @(negedge clk);
        check("ready_in_done", 32'(o_ready), 32'd1);
        i_val = 8'h03; i_sign = 1'b1; i_start = 1'b1;
        sb_q.push_back(9'h1FD); acc_cnt++;
        @(negedge clk);
        i_start = 1'b0;
        check("negzero_done", 32'(o_done), 32'd1);
        check("b2b_busy", 32'(o_ready), 32'd0);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (o_done === 1'b1) begin
                lat = k;
                break;
            end
        end
        check("b2b_gap", lat, 9);

        // Start pulse and operand changes during CONV must be ignored.
        @(negedge clk);
        wait_ready();
        i_val = 8'h5A; i_sign = 1'b1; i_start = 1'b1;
        sb_q.push_back(9'h1A6); acc_cnt++;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) i_start = 1'b0;
            if (k == 3) begin i_start = 1'b1; i_val = 8'h07; i_sign = 1'b0; end
            if (k == 4) i_start = 1'b0;
            if (o_done === 1'b1) begin
                lat = k;
                break;
            end
        end
        check("busy_latency", lat, 10);
        @(negedge clk);
        snap = done_cnt;
        repeat (15) @(negedge clk);
        check("busy_no_extra_done", done_cnt, snap);

        // Reset on the 4th CONV cycle discards the partial result.
        wait_ready();
        i_val = 8'h33; i_sign = 1'b1; i_start = 1'b1;
        snap = done_cnt;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            i_start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_o_done", 32'(o_done), 32'd0);
        check("midrst_o_val", 32'(o_val), 32'h0);
        check("midrst_o_ready", 32'(o_ready), 32'd1);
        repeat (15) @(negedge clk);
        check("midrst_no_done", done_cnt, snap);

        // Reset and start together: reset wins, nothing is accepted.
        rst = 1'b1; i_start = 1'b1; i_val = 8'h44; i_sign = 1'b0;
        @(negedge clk);
        rst = 1'b0; i_start = 1'b0;
        check("rst_start_ready", 32'(o_ready), 32'd1);
        repeat (15) @(negedge clk);
        check("rst_start_no_done", done_cnt, snap);

        // Random operands with random gaps; gap 0 exercises starts in the DONE cycle.
        for (int n = 0; n < 1000; n++) begin
            w = 0;
            while (o_ready !== 1'b1 && w < 50) begin
                @(negedge clk);
                w++;
            end
            if (o_ready !== 1'b1) begin
                check("rand_ready_timeout", 32'(o_ready), 32'd1);
                break;
            end
            rv = DW'($urandom);
            rs = 1'($urandom);
            i_val = rv; i_sign = rs; i_start = 1'b1;
            sb_q.push_back(model(rv, rs)); acc_cnt++;
            @(negedge clk);
            i_start = 1'b0;
            i_val = DW'($urandom); i_sign = 1'($urandom);
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
        end

        w = 0;
        while (sb_q.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        check("done_count", done_cnt, acc_cnt);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/comp2_recomposer.md
Name: comp2_recomposer

Overview:
- Sequential converter from sign-magnitude to two's complement: the inverse of the signed-operand decomposition stage in the Practica_1 datapath.
- Takes an unsigned DW-bit magnitude plus a sign bit and produces a (DW+1)-bit two's complement value.
- Converts serially, LSB first, one bit per clock, using the copy-through-first-1-then-invert rule.
- Sits at the output of the sequential arithmetic core and re-applies the sign to the result magnitude.

Parameters:
- DW, 8, magnitude width in bits; output width is DW+1. Legal range DW >= 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- i_start  input  1  request; accepted only while o_ready=1.
- i_val  input  DW  unsigned magnitude; sampled on the accepted i_start.
- i_sign  input  1  1 = negative, 0 = positive; sampled with i_val.
- o_val  output  DW+1  two's complement result; valid and held from o_done until the next accepted start.
- o_ready  output  1  1 in IDLE and DONE; block can accept i_start.
- o_done  output  1  single-cycle pulse when o_val is updated.

Behaviour:
- Reset, applied on a clk edge with rst=1: state=IDLE, o_val=0, o_ready=1, o_done=0, bit counter=0, seen_one=0, internal shift registers=0.
- States: IDLE, CONV, DONE.
- IDLE:
  - If i_start=1, capture i_val into the input shift register and i_sign into sign_q.
  - Clear seen_one and load counter=0, then go to CONV.
  - Otherwise stay in IDLE.
- CONV (exactly DW cycles):
  - Each cycle, take b = input register LSB.
  - Output bit = b XOR (sign_q AND seen_one), where seen_one is the value before this cycle.
  - Then seen_one <= seen_one OR b.
  - Shift the output bit into the MSB side of the output shift register, shift the input register right, and increment the counter.
  - When counter = DW-1, go to DONE.
  - o_ready=0 throughout CONV.
- DONE (one cycle):
  - o_val <= {sign_q AND seen_one, output shift register}, so the final bit DW is set only for a nonzero negative value.
  - o_done=1 and o_ready=1.
  - If i_start=1 in this cycle, capture the new operands and go directly to CONV (back-to-back operation). Otherwise go to IDLE.
- Latency: i_start accepted at edge N, then o_done is high during the cycle after edge N+DW+1 with o_val updated at that same edge. Throughput is one result per DW+1 cycles.
- Arithmetic result: o_val = i_sign ? -(zero-extended i_val) : zero-extended i_val, modulo 2^(DW+1).
- Boundary conditions:
  - Negative zero (i_val=0, i_sign=1) gives o_val=0; bit DW stays 0.
  - Largest magnitude (2^DW - 1) negated gives 2^DW + 1 in DW+1 bits. No overflow is possible.
  - i_start while in CONV is ignored; no queueing, and captured operands are not disturbed.
  - Changes on i_val/i_sign after capture have no effect.
  - rst=1 at any point, including mid-CONV, forces the reset values on the next edge; a partial result is discarded and o_done is not pulsed.
  - rst and i_start high together: reset wins.
  - o_val holds its last value indefinitely in IDLE.

Test Plan:
- Reset then idle: after rst, o_val=9'h000, o_ready=1, o_done=0; hold i_start=0 for 20 cycles and the outputs stay unchanged.
- Positive pass-through, DW=8: i_val=8'hC8, i_sign=0, start at edge N -> o_done after edge N+9, o_val=9'h0C8, o_ready=0 for exactly 8 cycles.
- Negative values, DW=8:
  - i_val=5, sign=1 -> o_val=9'h1FB.
  - i_val=8'hFF, sign=1 -> o_val=9'h101.
  - i_val=1, sign=1 -> o_val=9'h1FF.
  - i_val=8'h80, sign=1 -> o_val=9'h180.
- Negative zero and back-to-back:
  - i_val=0, sign=1 -> o_val=9'h000.
  - Assert i_start in the DONE cycle with i_val=3, sign=1 -> the next o_done pulse arrives exactly 9 cycles later with o_val=9'h1FD.
- Busy and reset:
  - Pulse i_start with i_val=7, sign=0 during CONV -> ignored, and the current result completes correctly.
  - Assert rst on the 4th CONV cycle -> no o_done pulse, o_val=0, o_ready=1 on the next cycle.
- Random self-check: 1000 random {i_val, i_sign} with random start gaps; each o_val compared against sign ? -mag : mag in DW+1 bits, and o_done pulse count equals the accepted start count.
